// File: rtl/lcd_write_engine.sv
// HD44780 byte-write engine: turns valid/ready host writes (and an optional
// power-on init sequence) into LCD_EN strobes with setup, hold and execution waits.
module lcd_write_engine #(
  parameter bit          INIT_EN     = 1'b1,
  parameter int unsigned T_POWER_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 25,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2500,
  parameter int unsigned T_LONG_CYC  = 82000,
  parameter int unsigned T_GAP_CYC   = 205000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_valid_i,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } state_t;

  localparam logic [19:0] POWER_LD = 20'(T_POWER_CYC);
  localparam logic [19:0] SETUP_LD = 20'(T_SETUP_CYC - 1);
  localparam logic [19:0] EN_LD    = 20'(T_EN_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(T_HOLD_CYC - 1);
  localparam logic [19:0] EXEC_LD  = 20'(T_EXEC_CYC - 1);
  localparam logic [19:0] LONG_LD  = 20'(T_LONG_CYC - 1);
  localparam logic [19:0] GAP_LD   = 20'(T_GAP_CYC - 1);

  state_t      state_reg;
  logic [19:0] cnt_reg;
  logic [2:0]  step_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [7:0]  data_reg;
  logic        rs_reg;
  logic        en_reg;
  logic        on_reg;

  logic [7:0]  init_byte;
  logic        is_long;
  logic [19:0] wait_ld;
  logic        early_ready;
  logic        accept;

  always_comb begin
    init_byte = 8'h06;
    case (step_reg)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h38;
      3'd2:    init_byte = 8'h38;
      3'd3:    init_byte = 8'h0C;
      3'd4:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end

  // Clear display / return home need the long execution wait.
  assign is_long = !rs_reg && (data_reg[7:2] == 6'd0) && (data_reg[1:0] != 2'd0);

  always_comb begin
    wait_ld = EXEC_LD;
    if (!done_reg)
      wait_ld = (step_reg == 3'd0) ? GAP_LD : LONG_LD;
    else if (is_long)
      wait_ld = LONG_LD;
  end

  // Ready is raised one cycle before EXEC ends so a pending write is taken
  // on the very edge the wait expires, giving back-to-back strobes no gap.
  assign early_ready = done_reg && (wait_ld == 20'd0);
  assign accept      = wr_valid_i && ready_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= INIT_EN ? POWER_WAIT : IDLE;
      cnt_reg   <= POWER_LD;
      step_reg  <= 3'd0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      data_reg  <= 8'h00;
      rs_reg    <= 1'b0;
      en_reg    <= 1'b0;
      on_reg    <= 1'b0;
    end else begin
      on_reg <= 1'b1;
      if (accept) begin
        data_reg  <= wr_data_i;
        rs_reg    <= wr_rs_i;
        state_reg <= SETUP;
        cnt_reg   <= SETUP_LD;
        ready_reg <= 1'b0;
        busy_reg  <= 1'b1;
      end else begin
        case (state_reg)
          POWER_WAIT: begin
            busy_reg <= 1'b1;
            if (cnt_reg == 20'd0) state_reg <= INIT_LOAD;
            else                  cnt_reg   <= cnt_reg - 20'd1;
          end
          INIT_LOAD: begin
            data_reg  <= init_byte;
            rs_reg    <= 1'b0;
            state_reg <= SETUP;
            cnt_reg   <= SETUP_LD;
          end
          SETUP: begin
            if (cnt_reg == 20'd0) begin
              state_reg <= PULSE;
              en_reg    <= 1'b1;
              cnt_reg   <= EN_LD;
            end else begin
              cnt_reg <= cnt_reg - 20'd1;
            end
          end
          PULSE: begin
            if (cnt_reg == 20'd0) begin
              state_reg <= HOLD;
              en_reg    <= 1'b0;
              cnt_reg   <= HOLD_LD;
            end else begin
              cnt_reg <= cnt_reg - 20'd1;
            end
          end
          HOLD: begin
            if (cnt_reg == 20'd0) begin
              state_reg <= EXEC;
              cnt_reg   <= wait_ld;
              ready_reg <= early_ready;
              busy_reg  <= !early_ready;
            end else begin
              cnt_reg <= cnt_reg - 20'd1;
            end
          end
          EXEC: begin
            if (cnt_reg != 20'd0) begin
              cnt_reg <= cnt_reg - 20'd1;
              if (cnt_reg == 20'd1 && done_reg) begin
                ready_reg <= 1'b1;
                busy_reg  <= 1'b0;
              end
            end else if (!done_reg) begin
              if (step_reg == 3'd5) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
                ready_reg <= 1'b1;
                busy_reg  <= 1'b0;
              end else begin
                step_reg  <= step_reg + 3'd1;
                state_reg <= INIT_LOAD;
              end
            end else begin
              state_reg <= IDLE;
            end
          end
          IDLE: begin
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign wr_ready_o  = ready_reg;
  assign busy_o      = busy_reg;
  assign init_done_o = done_reg;
  assign lcd_data_o  = data_reg;
  assign lcd_rs_o    = rs_reg;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_reg;
  assign lcd_on_o    = on_reg;

endmodule
